// File: rtl/winograd_f63_conv_if.sv
// rtl/winograd_f63_conv_if.sv - tile port bundle for winograd_f63_conv
// D carries eight signed 10-bit samples in, Z carries six signed 10-bit results out.
interface winograd_f63_conv_if;
   logic [79:0] D;
   logic [59:0] Z;

   modport master (output D, input Z);
   modport slave  (input D, output Z);
endinterface

// File: rtl/winograd_f63_conv.sv
// rtl/winograd_f63_conv.sv - 4-stage Winograd F(6,3) 3-tap correlation tile
// Optional macro WC_OUT_SAT_EN: saturate outputs to [-512,511] instead of wrapping.
module winograd_f63_conv #(
   parameter int G0 = 2,
   parameter int G1 = -3,
   parameter int G2 = 1
) (
   input logic                clk,
   input logic                rst,
   winograd_f63_conv_if.slave tile
);

   localparam int TW = 18;
   localparam int MW = 36;
   localparam int AW = 48;

   // B^T scaled by 4, G scaled by 90, A^T scaled by 32: total scale 11520 = 256*45
   localparam int BT [8][8] = '{
      '{4,  0, -21,   0,  21,   0, -4, 0},
      '{0,  4,   4, -17, -17,   4,  4, 0},
      '{0, -4,   4,  17, -17,  -4,  4, 0},
      '{0,  2,   1, -10,  -5,   8,  4, 0},
      '{0, -2,   1,  10,  -5,  -8,  4, 0},
      '{0,  8,  16, -10, -20,   2,  4, 0},
      '{0, -8,  16,  10, -20,  -2,  4, 0},
      '{0, -4,   0,  21,   0, -21,  0, 4}
   };

   localparam int GT [8] = '{
      90 * G0,
      -20 * (G0 + G1 + G2),
      -20 * (G0 - G1 + G2),
      G0 + 2 * G1 + 4 * G2,
      G0 - 2 * G1 + 4 * G2,
      64 * G0 + 32 * G1 + 16 * G2,
      64 * G0 - 32 * G1 + 16 * G2,
      90 * G2
   };

   localparam int AT [6][8] = '{
      '{32, 32,  32,   32,    32, 32, 32,  0},
      '{0,  32, -32,   64,   -64, 16, -16, 0},
      '{0,  32,  32,  128,   128,  8,  8,  0},
      '{0,  32, -32,  256,  -256,  4, -4,  0},
      '{0,  32,  32,  512,   512,  2,  2,  0},
      '{0,  32, -32, 1024, -1024,  1, -1, 32}
   };

   logic signed [9:0]    d_q [8];
   logic signed [TW-1:0] t_d [8];
   logic signed [TW-1:0] t_q [8];
   logic signed [MW-1:0] m_d [8];
   logic signed [MW-1:0] m_q [8];
   logic        [59:0]   z_d;
   logic        [59:0]   z_q;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] y;

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         t_d[i] = '0;
         for (int j = 0; j < 8; j++) begin
            t_d[i] = t_d[i] + TW'(BT[i][j]) * TW'(d_q[j]);
         end
         m_d[i] = MW'(t_q[i]) * MW'(GT[i]);
      end
   end

   always_comb begin
      z_d = '0;
      acc = '0;
      y   = '0;
      for (int i = 0; i < 6; i++) begin
         acc = '0;
         for (int j = 0; j < 8; j++) begin
            acc = acc + AW'(AT[i][j]) * AW'(m_q[j]);
         end
         // exact descale: remainder of both steps is zero by construction
         y = (acc >>> 8) / AW'(45);
`ifdef WC_OUT_SAT_EN
         if (y > AW'(511)) begin
            z_d[59-10*i -: 10] = 10'h1ff;
         end else if (y < -AW'(512)) begin
            z_d[59-10*i -: 10] = 10'h200;
         end else begin
            z_d[59-10*i -: 10] = 10'(y);
         end
`else
         z_d[59-10*i -: 10] = 10'(y);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            d_q[i] <= '0;
            t_q[i] <= '0;
            m_q[i] <= '0;
         end
         z_q <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            d_q[i] <= tile.D[79-10*i -: 10];
            t_q[i] <= t_d[i];
            m_q[i] <= m_d[i];
         end
         z_q <= z_d;
      end
   end

   assign tile.Z = z_q;

endmodule

// File: tb/tb_winograd_f63_conv.sv
// tb/tb_winograd_f63_conv.sv - directed self-checking bench for winograd_f63_conv
module tb_winograd_f63_conv;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   winograd_f63_conv_if tile ();

   winograd_f63_conv #(.G0(2), .G1(-3), .G2(1)) dut (
      .clk  (clk),
      .rst  (rst),
      .tile (tile)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [59:0] obs, input logic [59:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [79:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
      return {10'(a0), 10'(a1), 10'(a2), 10'(a3), 10'(a4), 10'(a5), 10'(a6), 10'(a7)};
   endfunction

   function automatic logic [59:0] pk6(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5);
      return {10'(a0), 10'(a1), 10'(a2), 10'(a3), 10'(a4), 10'(a5)};
   endfunction

   logic [79:0] t1_in, t2_in;
   logic [59:0] t1_exp, t2_exp;
   logic [79:0] vin  [6];
   logic [59:0] vexp [6];

   initial begin
      t1_in  = pk8(2, -10, 3, 4, -13, -18, -16, -28);
      t1_exp = pk6(37, -25, -19, 29, 12, -16);
      t2_in  = pk8(-19, -6, 3, -9, -12, 11, -4, 0);
      t2_exp = pk6(-17, -30, 21, 29, -61, 34);

      vin[0] = pk8(0, 0, 1, 0, 0, 0, 0, 0);  vexp[0] = pk6(1, -3, 2, 0, 0, 0);
      vin[1] = pk8(1, 0, 0, 0, 0, 0, 0, 0);  vexp[1] = pk6(2, 0, 0, 0, 0, 0);
      vin[2] = pk8(0, 0, 0, 0, 0, 1, 0, 0);  vexp[2] = pk6(0, 0, 0, 1, -3, 2);
      vin[3] = pk8(0, 0, 0, 0, 0, 0, 0, 1);  vexp[3] = pk6(0, 0, 0, 0, 0, 1);
      vin[4] = pk8(0, 0, 0, 0, 0, 0, 0, -1); vexp[4] = pk6(0, 0, 0, 0, 0, -1);
      vin[5] = pk8(511, -512, 511, -512, 511, -512, 511, -512);
`ifdef WC_OUT_SAT_EN
      vexp[5] = pk6(511, -512, 511, -512, 511, -512);
`else
      vexp[5] = pk6(-3, 3, -3, 3, -3, 3);
`endif

      // reset held with nonzero input
      rst    = 1'b0;
      tile.D = t1_in;
      tick(3);
      chk("rst_hold", tile.Z, '0);

      tile.D = '0;
      rst    = 1'b1;
      tick(5);
      chk("rst_rel", tile.Z, '0);

      // latency: nothing after three edges, result after the fourth
      tile.D = t1_in;
      tick(3);
      chk("lat3", tile.Z, '0);
      tick(1);
      chk("tile1", tile.Z, t1_exp);
      tick(3);
      chk("tile1_hold", tile.Z, t1_exp);

      // back-to-back tiles after a zero flush
      tile.D = '0;
      tick(4);
      chk("flush", tile.Z, '0);
      tile.D = t1_in;
      tick(1);
      tile.D = t2_in;
      tick(3);
      chk("b2b_t1", tile.Z, t1_exp);
      tick(1);
      chk("b2b_t2", tile.Z, t2_exp);
      tick(2);
      chk("b2b_t2_hold", tile.Z, t2_exp);

      for (int k = 0; k < 6; k++) begin
         tile.D = vin[k];
         tick(4);
         chk($sformatf("vec%0d", k), tile.Z, vexp[k]);
      end

      // reset mid-stream discards the in-flight tile
      tile.D = t2_in;
      tick(4);
      chk("pre_rst", tile.Z, t2_exp);
      tile.D = t1_in;
      tick(2);
      #1 rst = 1'b0;
      #1 chk("rst_async", tile.Z, '0);
      tile.D = vin[1];
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         chk($sformatf("no_t1_%0d", k), tile.Z, '0);
      end
      tick(1);
      chk("post_rst", tile.Z, vexp[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
